// File: rtl/sorted_stream_tx_if.sv
// Output stream of sorted_stream_tx: element data, index, last flag and
// a valid/ready handshake. The transmitter uses master, the sink uses slave.
interface sorted_stream_tx_if #(
    parameter int DIGIT = 4
);
    logic [DIGIT-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_index;
    logic             out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_index,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/sorted_stream_tx.sv
// Captures the 4-entry sorter result on each rising edge of done_in and streams it out s0 first.
// Optional order check of the captured vector: define SORTED_STREAM_ORDER_CHECK_EN.
module sorted_stream_tx #(
    parameter int DIGIT = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             done_in,
    input  logic [DIGIT-1:0] s0_in,
    input  logic [DIGIT-1:0] s1_in,
    input  logic [DIGIT-1:0] s2_in,
    input  logic [DIGIT-1:0] s3_in,
    sorted_stream_tx_if.master tx,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun,
    output logic             order_err
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [3:0][DIGIT-1:0] buf_q, buf_d;
    logic [1:0]            idx_q, idx_d;
    logic                  done_q;
    logic                  frame_done_q, frame_done_d;
    logic                  overrun_q, overrun_d;
    logic                  load;
    logic                  hs;
    logic                  accept;

    // done_in is a level; only its rising edge starts a frame.
    assign load   = done_in & ~done_q;
    assign hs     = tx.out_valid & tx.out_ready;
    assign accept = load & (state_q == IDLE);

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        overrun_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    buf_d   = {s3_in, s2_in, s1_in, s0_in};
                    idx_d   = 2'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                // A new result while a frame is in flight is dropped, not queued.
                overrun_d = load;
                if (hs) begin
                    if (idx_q == 2'd3) begin
                        state_d      = IDLE;
                        idx_d        = 2'd0;
                        frame_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            buf_q        <= '0;
            idx_q        <= 2'd0;
            done_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            idx_q        <= idx_d;
            done_q       <= done_in;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign tx.out_valid = (state_q == SEND);
    assign tx.out_data  = tx.out_valid ? buf_q[idx_q] : '0;
    assign tx.out_index = idx_q;
    assign tx.out_last  = tx.out_valid & (idx_q == 2'd3);
    assign busy         = (state_q == SEND);
    assign frame_done   = frame_done_q;
    assign overrun      = overrun_q;

`ifdef SORTED_STREAM_ORDER_CHECK_EN
    logic order_err_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            order_err_q <= 1'b0;
        end else if (accept) begin
            order_err_q <= !((s0_in <= s1_in) && (s1_in <= s2_in) && (s2_in <= s3_in));
        end
    end

    assign order_err = order_err_q;
`else
    assign order_err = 1'b0;
`endif

endmodule
